bram_dp_responder: RTL
======================

// Module: bram_dp_responder
// PURPOSE
//  Single-clock true-dual-port 32-bit block-RAM responder. Answers the BRAM port protocol
//  (addr/din/dout/en/rst/we) driven by the team's BRAM test masters on ports A and B.
//  Used in simulation and on-chip as a drop-in target with init, collision and range checking.
// PARAMETERS
//  DATA_W    32    word width; multiple of 8; NB = DATA_W/8 byte lanes
//  ADDR_W    32    byte-address width on both ports
//  DEPTH     1024  words; power of two; AW = log2(DEPTH)
//  WR_MODE   0     0 = read-first (dout = old word on write), 1 = write-first (dout = merged new word)
//  INIT_VAL  0     value written to every word by the init sweep
// PORTS
//  clk       in   1       clock (single domain; both BRAM ports use it)
//  reset     in   1       synchronous, active-low
//  addra     in   ADDR_W  port A byte address; word index = addra[AW+1:2]
//  dina      in   DATA_W  port A write data
//  douta     out  DATA_W  port A read data
//  ena       in   1       port A enable
//  rsta      in   1       port A output reset
//  wea       in   NB      port A byte write enables
//  addrb/dinb/doutb/enb/rstb/web   same as port A, for port B
//  init_done out  1       1 = init sweep finished, ports live
//  coll      out  1       1-cycle pulse: same-word access with >=1 write
//  oor       out  1       1-cycle pulse: enabled access with out-of-range or unaligned address
//  coll_cnt  out  16      saturating collision count
// BEHAVIOUR
//  Reset (reset=0): douta=doutb=0, init_done=0, coll=oor=0, coll_cnt=0, FSM -> INIT, sweep ptr=0.
//  FSM INIT: one word per cycle, mem[ptr]=INIT_VAL, ptr++. After word DEPTH-1 -> RUN, init_done=1.
//   - Sweep takes DEPTH cycles after reset release.
//   - Port inputs ignored and douts held 0 while in INIT.
//   - reset during INIT restarts the sweep at word 0.
//  FSM RUN: ports serviced every cycle; leaves RUN only on reset. Every reset re-initialises memory.
//  Range rule: address illegal if addr[1:0]!=0 or addr >= DEPTH*4.
//   - Illegal enabled access: write dropped, dout<=0, oor pulses next cycle.
//  Per port, en=1 and legal:
//   - byte i with we[i]=1: mem byte i <= din[8i+7:8i].
//   - dout updates 1 cycle later: old word if WR_MODE=0; merged word if WR_MODE=1.
//  en=0: memory untouched, dout holds.
//  rst=1: dout<=0 next cycle, regardless of en; has priority over the read; memory write still occurs.
//  Collision: both en=1, legal, same word, and (wea!=0 or web!=0).
//   - Byte written by both ports: A wins.
//   - Reader sees old word.
//   - Each writer's own dout follows WR_MODE.
//   - coll pulses 1 cycle later; coll_cnt++, saturating at 16'hFFFF.
//  All outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  BRAM_OUTREG_EN defined:
//   - Extra output register per port; read latency 2 cycles.
//   - rst clears this output stage; the first stage is unaffected.
//   - coll and oor remain at 1-cycle latency.
//  BRAM_OUTREG_EN undefined:
//   - Read latency 1 cycle; rst clears dout directly.
// TESTING
//  Init: release reset, count cycles -> init_done rises exactly DEPTH cycles later; reads of words 0 and DEPTH-1 return INIT_VAL.
//  Write/read A->B: A writes dina=0,10,..,90 at addra=0,4,..,36 with wea=4'hF; B reads same addrs -> doutb=0,10,..,90 at latency 1 (2 with macro).
//  Byte lanes: mem[2]=0x11223344, A writes 0xAABBCCDD with wea=4'b0101 -> readback 0x11BB33DD.
//  Collision: same cycle A writes 0x1 we=F, B writes 0x2 we=F at addr 8 -> mem=0x1, coll=1 for one cycle, coll_cnt=1.
//   - Read-first: A reads 0x5 while B writes 0x6 at same word -> douta=0x5, coll pulses.
//  Range/rst: ena=1 addra=0x2 -> oor pulses, douta=0, no write.
//   - addra=DEPTH*4 -> oor pulses, douta=0, no write.
//   - rsta=1 during a read -> douta=0.
//  Mid-op reset: reset low while writing -> all outputs 0; after re-init, previously written word reads INIT_VAL.

Source files
------------

// File: rtl/bram_dp_responder.sv
// True-dual-port BRAM responder with init sweep, collision and range checking.
// Optional BRAM_OUTREG_EN adds a second output register per port (read latency 2).
module bram_dp_responder #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 1024,
    parameter int              WR_MODE  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    output logic [DATA_W-1:0]   douta,
    input  logic                ena,
    input  logic                rsta,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addrb,
    input  logic [DATA_W-1:0]   dinb,
    output logic [DATA_W-1:0]   doutb,
    input  logic                enb,
    input  logic                rstb,
    input  logic [DATA_W/8-1:0] web,
    output logic                init_done,
    output logic                coll,
    output logic                oor,
    output logic [15:0]         coll_cnt
);
    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic [AW-1:0]     ia, ib;
    logic              legal_a, legal_b;
    logic [NB-1:0]     wr_a, wr_b;
    logic [DATA_W-1:0] old_a, old_b, mrg_a, mrg_b, nxt_a, nxt_b;
    logic              coll_d, oor_d, coll_q, oor_q;
    logic [15:0]       coll_cnt_q;
    logic [DATA_W-1:0] douta_q, doutb_q;

    assign run     = (state_q == S_RUN);
    assign ia      = addra[AW+1:2];
    assign ib      = addrb[AW+1:2];
    assign legal_a = (addra[1:0] == 2'b00) && (addra[ADDR_W-1:AW+2] == '0);
    assign legal_b = (addrb[1:0] == 2'b00) && (addrb[ADDR_W-1:AW+2] == '0);
    assign wr_a    = (run && ena && legal_a) ? wea : '0;
    assign wr_b    = (run && enb && legal_b) ? web : '0;
    assign old_a   = mem[ia];
    assign old_b   = mem[ib];

    always_comb begin
        mrg_a = old_a;
        mrg_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (wea[i]) mrg_a[8*i+:8] = dina[8*i+:8];
            if (web[i]) mrg_b[8*i+:8] = dinb[8*i+:8];
        end
        nxt_a = '0;
        nxt_b = '0;
        if (legal_a) nxt_a = (WR_MODE != 0) ? mrg_a : old_a;
        if (legal_b) nxt_b = (WR_MODE != 0) ? mrg_b : old_b;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == AW'(DEPTH - 1)) state_d = S_RUN;
            end
            S_RUN: ;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // B is written first so that A's bytes override on a shared word.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (!run) begin
                mem[ptr_q] <= INIT_VAL;
            end else begin
                for (int i = 0; i < NB; i++)
                    if (wr_b[i]) mem[ib][8*i+:8] <= dinb[8*i+:8];
                for (int i = 0; i < NB; i++)
                    if (wr_a[i]) mem[ia][8*i+:8] <= dina[8*i+:8];
            end
        end
    end

`ifdef BRAM_OUTREG_EN
    logic [DATA_W-1:0] s1a_q, s1b_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1a_q   <= '0;
            s1b_q   <= '0;
            douta_q <= '0;
            doutb_q <= '0;
        end else begin
            if (run && ena) s1a_q <= nxt_a;
            if (run && enb) s1b_q <= nxt_b;
            douta_q <= (rsta || !run) ? '0 : s1a_q;
            doutb_q <= (rstb || !run) ? '0 : s1b_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset || !run) begin
            douta_q <= '0;
            doutb_q <= '0;
        end else begin
            if (rsta)     douta_q <= '0;
            else if (ena) douta_q <= nxt_a;
            if (rstb)     doutb_q <= '0;
            else if (enb) doutb_q <= nxt_b;
        end
    end
`endif

    assign coll_d = run && ena && enb && legal_a && legal_b
                    && (ia == ib) && ((|wea) || (|web));
    assign oor_d  = run && ((ena && !legal_a) || (enb && !legal_b));

    always_ff @(posedge clk) begin
        if (!reset) begin
            coll_q     <= 1'b0;
            oor_q      <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            coll_q <= coll_d;
            oor_q  <= oor_d;
            if (coll_d && coll_cnt_q != 16'hFFFF)
                coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    assign douta     = douta_q;
    assign doutb     = doutb_q;
    assign init_done = run;
    assign coll      = coll_q;
    assign oor       = oor_q;
    assign coll_cnt  = coll_cnt_q;
endmodule
